// File: rtl/gb_apu_sweep_unit.sv
// Game Boy APU channel-1 frequency sweep: shadow register, sweep timer and overflow
// handling, including the negate-lockout channel-disable quirk.
module gb_apu_sweep_unit #(
   parameter int FREQ_W      = 11,
   parameter int PACE_W      = 3,
   parameter int SHIFT_W     = 3,
   parameter int NEGATE_LOCK = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clk_sweep,
   input  logic               trigger,
   input  logic [PACE_W-1:0]  sweep_pace,
   input  logic               sweep_decreasing,
   input  logic [SHIFT_W-1:0] num_sweep_shifts,
   input  logic [FREQ_W-1:0]  frequency,
   output logic [FREQ_W-1:0]  shadow_frequency,
   output logic               freq_update,
   output logic               overflow,
   output logic               sweep_active
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_CALC,
      S_CHECK,
      S_OVERFLOW
   } state_t;

   localparam logic [PACE_W:0] TIMER_ONE = {{PACE_W{1'b0}}, 1'b1};
   localparam logic [PACE_W:0] TIMER_MAX = {1'b1, {PACE_W{1'b0}}};

   // One extra bit so an add that leaves the FREQ_W range is visible as the MSB.
   function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0]  base,
                                                   input logic [SHIFT_W-1:0] shifts,
                                                   input logic               decr);
      logic [FREQ_W:0] delta;
      delta = {1'b0, (base >> shifts)};
      return decr ? ({1'b0, base} - delta) : ({1'b0, base} + delta);
   endfunction

   function automatic logic sweep_ovf(input logic [FREQ_W:0] value);
      return value[FREQ_W];
   endfunction

   state_t            state_q;
   state_t            state_d;
   logic [PACE_W:0]   timer;
   logic              negate_used;

   logic [FREQ_W:0]   cur_calc;
   logic              cur_ovf;
   logic              trig_ovf;
   logic              trig_active;
   logic              shift_nz;
   logic              running;
   logic              expire;
   logic              lock_hit;
   logic [PACE_W:0]   reload_val;

   logic              shadow_write;
   logic              ovf_set;
   logic              neg_set;
   logic              timer_step;

   assign shift_nz    = (num_sweep_shifts != '0);
   assign cur_calc    = sweep_calc(shadow_frequency, num_sweep_shifts, sweep_decreasing);
   assign cur_ovf     = sweep_ovf(cur_calc);
   assign trig_ovf    = shift_nz &&
                        sweep_ovf(sweep_calc(frequency, num_sweep_shifts, sweep_decreasing));
   assign trig_active = (sweep_pace != '0) || shift_nz;
   assign reload_val  = (sweep_pace == '0) ? TIMER_MAX : {1'b0, sweep_pace};
   assign running     = (state_q == S_ARMED) || (state_q == S_CALC) || (state_q == S_CHECK);
   assign expire      = clk_sweep && (timer == TIMER_ONE);
   // Having subtracted once, switching back to addition kills the channel.
   assign lock_hit    = (NEGATE_LOCK != 0) && negate_used && !sweep_decreasing && running;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (trigger) begin
         if (trig_ovf) begin
            state_d = S_OVERFLOW;
         end else if (trig_active) begin
            state_d = S_ARMED;
         end else begin
            state_d = S_IDLE;
         end
      end else if (lock_hit) begin
         state_d = S_OVERFLOW;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (expire && (sweep_pace != '0)) begin
                  state_d = S_CALC;
               end
            end
            S_CALC: begin
               if (cur_ovf) begin
                  state_d = S_OVERFLOW;
               end else if (shift_nz) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_ARMED;
               end
            end
            S_CHECK: begin
               state_d = cur_ovf ? S_OVERFLOW : S_ARMED;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      shadow_write = 1'b0;
      ovf_set      = 1'b0;
      neg_set      = 1'b0;
      timer_step   = 1'b0;
      if (!trigger) begin
         timer_step = running && clk_sweep;
         if (lock_hit) begin
            ovf_set = 1'b1;
         end else begin
            if ((state_q == S_CALC) || (state_q == S_CHECK)) begin
               ovf_set = cur_ovf;
            end
            if (state_q == S_CALC) begin
               shadow_write = !cur_ovf && shift_nz;
               neg_set      = sweep_decreasing && shift_nz;
            end
         end
      end
   end

   // Trigger reloads everything and wins over any sweep activity in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_frequency <= '0;
         freq_update      <= 1'b0;
         overflow         <= 1'b0;
         sweep_active     <= 1'b0;
         timer            <= '0;
         negate_used      <= 1'b0;
      end else begin
         freq_update <= shadow_write;
         if (trigger) begin
            shadow_frequency <= frequency;
            timer            <= reload_val;
            overflow         <= trig_ovf;
            negate_used      <= shift_nz && sweep_decreasing;
            sweep_active     <= trig_active;
         end else begin
            if (shadow_write) begin
               shadow_frequency <= cur_calc[FREQ_W-1:0];
            end
            if (ovf_set) begin
               overflow <= 1'b1;
            end
            if (neg_set) begin
               negate_used <= 1'b1;
            end
            if (timer_step) begin
               timer <= (timer == TIMER_ONE) ? reload_val : (timer - TIMER_ONE);
            end
         end
      end
   end

endmodule

// File: tb/tb_gb_apu_sweep_unit.sv
// Scoreboard bench for gb_apu_sweep_unit: two instances (negate lockout on/off) driven
// by the same stimulus, checked against an event-level sweep model.
module tb_gb_apu_sweep_unit;

   localparam int FMAX = 2047;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_sweep = 1'b0;
   logic        trigger = 1'b0;
   logic [2:0]  pace = '0;
   logic        decr = 1'b0;
   logic [2:0]  shifts = '0;
   logic [10:0] freq = '0;

   logic [10:0] sh0, sh1;
   logic        fu0, fu1, ov0, ov1, act0, act1;

   gb_apu_sweep_unit #(.FREQ_W(11), .PACE_W(3), .SHIFT_W(3), .NEGATE_LOCK(1)) dut0 (
      .clk(clk), .reset(reset), .clk_sweep(clk_sweep), .trigger(trigger),
      .sweep_pace(pace), .sweep_decreasing(decr), .num_sweep_shifts(shifts),
      .frequency(freq), .shadow_frequency(sh0), .freq_update(fu0),
      .overflow(ov0), .sweep_active(act0));

   gb_apu_sweep_unit #(.FREQ_W(11), .PACE_W(3), .SHIFT_W(3), .NEGATE_LOCK(0)) dut1 (
      .clk(clk), .reset(reset), .clk_sweep(clk_sweep), .trigger(trigger),
      .sweep_pace(pace), .sweep_decreasing(decr), .num_sweep_shifts(shifts),
      .frequency(freq), .shadow_frequency(sh1), .freq_update(fu1),
      .overflow(ov1), .sweep_active(act1));

   always #5 clk = ~clk;

   typedef struct {
      bit is_ovf;
      int val;
   } evt_t;

   evt_t q0[$];
   evt_t q1[$];
   int   checks = 0;
   int   errors = 0;

   int   m_sh[2];
   int   m_cnt[2];
   bit   m_ovf[2], m_act[2], m_alive[2], m_neg[2];
   bit   prev_ov[2];

   // ---------------- reference model ----------------
   function automatic int next_val(input int s);
      int delta;
      delta = s >> shifts;
      return decr ? (s - delta) : (s + delta);
   endfunction

   task automatic push(input int d, input bit o, input int v);
      evt_t e;
      e.is_ovf = o;
      e.val    = v;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_sh[d] = 0; m_cnt[d] = 0; m_ovf[d] = 0; m_act[d] = 0; m_alive[d] = 0; m_neg[d] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic model_trigger();
      for (int d = 0; d < 2; d++) begin
         m_sh[d]    = freq;
         m_cnt[d]   = 0;
         m_ovf[d]   = 0;
         m_act[d]   = (pace != 0) || (shifts != 0);
         m_neg[d]   = (shifts != 0) && decr;
         m_alive[d] = m_act[d];
         if (shifts != 0 && next_val(freq) > FMAX) begin
            m_ovf[d] = 1; m_alive[d] = 0;
            push(d, 1, freq);
         end
      end
   endtask

   task automatic model_tick();
      int v;
      for (int d = 0; d < 2; d++) begin
         if (m_alive[d] && pace != 0) begin
            m_cnt[d]++;
            if (m_cnt[d] == pace) begin
               m_cnt[d] = 0;
               v = next_val(m_sh[d]);
               if (v > FMAX) begin
                  m_ovf[d] = 1; m_alive[d] = 0;
                  push(d, 1, m_sh[d]);
               end else if (shifts != 0) begin
                  if (decr) m_neg[d] = 1;
                  m_sh[d] = v;
                  push(d, 0, v);
                  if (next_val(m_sh[d]) > FMAX) begin
                     m_ovf[d] = 1; m_alive[d] = 0;
                     push(d, 1, m_sh[d]);
                  end
               end
            end
         end
      end
   endtask

   task automatic model_decr();
      for (int d = 0; d < 2; d++) begin
         if (d == 0 && m_alive[d] && m_neg[d] && !decr) begin
            m_ovf[d] = 1; m_alive[d] = 0;
            push(d, 1, m_sh[d]);
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic check_evt(input int d, input bit is_ovf, input logic [10:0] s);
      evt_t e;
      bit   have;
      checks++;
      have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (!have) begin
         errors++;
         $display("FAIL dut%0d event: got %s shadow=%h, required no event", d,
                  is_ovf ? "overflow" : "freq_update", s);
      end else begin
         if (d == 0) e = q0.pop_front();
         else e = q1.pop_front();
         if (e.is_ovf != is_ovf || s !== 11'(e.val)) begin
            errors++;
            $display("FAIL dut%0d event: got %s shadow=%h, required %s shadow=%h", d,
                     is_ovf ? "overflow" : "freq_update", s,
                     e.is_ovf ? "overflow" : "freq_update", 11'(e.val));
         end
      end
   endtask

   task automatic mon(input int d, input logic fu, input logic ov, input logic [10:0] s);
      if (fu === 1'b1) check_evt(d, 1'b0, s);
      if (ov === 1'b1 && !prev_ov[d]) check_evt(d, 1'b1, s);
      prev_ov[d] = (ov === 1'b1);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_ov[0] = 0;
            prev_ov[1] = 0;
         end else begin
            mon(0, fu0, ov0, sh0);
            mon(1, fu1, ov1, sh1);
         end
      end
   end

   task automatic check_state(input string tag);
      expect_eq({tag, " dut0 shadow"}, 32'(sh0), m_sh[0]);
      expect_eq({tag, " dut0 overflow"}, 32'(ov0), 32'(m_ovf[0]));
      expect_eq({tag, " dut0 active"}, 32'(act0), 32'(m_act[0]));
      expect_eq({tag, " dut0 pending"}, q0.size(), 0);
      expect_eq({tag, " dut1 shadow"}, 32'(sh1), m_sh[1]);
      expect_eq({tag, " dut1 overflow"}, 32'(ov1), 32'(m_ovf[1]));
      expect_eq({tag, " dut1 active"}, 32'(act1), 32'(m_act[1]));
      expect_eq({tag, " dut1 pending"}, q1.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      expect_eq({tag, " dut0 outputs"}, {18'(sh0), fu0, ov0, act0}, 0);
      expect_eq({tag, " dut1 outputs"}, {18'(sh1), fu1, ov1, act1}, 0);
   endtask

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      cyc(1);
      reset = 1'b0;
      cyc(1);
   endtask

   task automatic do_trigger(input int f, input int p, input bit d, input int s);
      freq = 11'(f); pace = 3'(p); decr = d; shifts = 3'(s);
      trigger = 1'b1;
      model_trigger();
      cyc(1);
      trigger = 1'b0;
      cyc(2);
   endtask

   task automatic do_tick();
      clk_sweep = 1'b1;
      model_tick();
      cyc(1);
      clk_sweep = 1'b0;
      cyc(4);
   endtask

   task automatic set_decr(input bit d);
      decr = d;
      model_decr();
      cyc(3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      cyc(3);
      check_zero("reset");
      reset = 1'b0;
      cyc(1);

      // Decreasing sweep, three steps.
      do_reset();
      do_trigger('h040, 1, 1, 2);
      repeat (3) do_tick();
      check_state("decr3");
      expect_eq("decr3 literal shadow", 32'(sh0), 'h01B);

      // Overflow at trigger, then ticks ignored, then retrigger from OVERFLOW.
      do_reset();
      do_trigger('h600, 1, 0, 1);
      expect_eq("trig ovf literal", 32'(ov0), 1);
      repeat (2) do_tick();
      check_state("trig_ovf");
      expect_eq("trig ovf shadow literal", 32'(sh0), 'h600);
      do_trigger('h100, 2, 0, 1);
      repeat (4) do_tick();
      check_state("retrigger");

      // Overflow found by the post-write check.
      do_reset();
      do_trigger('h500, 1, 0, 2);
      repeat (2) do_tick();
      check_state("check_ovf");
      expect_eq("check ovf shadow literal", 32'(sh0), 'h7D0);

      // Pace zero: active but never steps.
      do_reset();
      do_trigger('h100, 0, 0, 1);
      repeat (16) do_tick();
      check_state("pace0");
      expect_eq("pace0 active literal", 32'(act0), 1);

      // Negate lockout.
      do_reset();
      do_trigger('h100, 1, 1, 1);
      do_tick();
      set_decr(1'b0);
      check_state("neglock");
      expect_eq("neglock dut0 ovf literal", 32'(ov0), 1);
      do_tick();
      check_state("neglock_tick");
      expect_eq("nolock dut1 shadow literal", 32'(sh1), 'h0C0);

      // Reset asserted while in CALC.
      do_reset();
      do_trigger('h040, 1, 1, 2);
      clk_sweep = 1'b1;
      cyc(1);
      clk_sweep = 1'b0;
      reset = 1'b1;
      model_reset();
      #1;
      check_zero("reset_mid_calc");
      cyc(1);
      reset = 1'b0;
      cyc(1);
      do_trigger('h040, 1, 1, 2);
      do_tick();
      check_state("after_reset");
      expect_eq("after reset shadow literal", 32'(sh0), 'h030);

      // Randomised scenarios.
      for (int n = 0; n < 30; n++) begin
         do_reset();
         do_trigger($urandom_range(0, 2047), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 7));
         for (int k = $urandom_range(1, 12); k > 0; k--) begin
            if ($urandom_range(0, 5) == 0) set_decr(!decr);
            else do_tick();
         end
         check_state("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gb_apu_sweep_unit.md
GB_APU_SWEEP_UNIT -- requirements
Module: gb_apu_sweep_unit

Interface
REQ-001 SHALL have parameter FREQ_W, default 11, width of the frequency and shadow registers.
REQ-002 SHALL have parameter PACE_W, default 3, width of the sweep_pace field.
REQ-003 SHALL have parameter SHIFT_W, default 3, width of the num_sweep_shifts field.
REQ-004 SHALL have parameter NEGATE_LOCK, default 1, enabling the negate-lockout channel-disable quirk.
REQ-005 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port clk_sweep, input, 1, one-cycle sweep tick enable (128 Hz frame-sequencer step).
REQ-008 SHALL have port trigger, input, 1, channel trigger, sampled every clk edge.
REQ-009 SHALL have port sweep_pace, input, PACE_W, ticks per sweep step; 0 means no stepping.
REQ-010 SHALL have port sweep_decreasing, input, 1, 1 = subtract, 0 = add.
REQ-011 SHALL have port num_sweep_shifts, input, SHIFT_W, right-shift amount for the delta.
REQ-012 SHALL have port frequency, input, FREQ_W, channel frequency register, sampled on trigger.
REQ-013 SHALL have port shadow_frequency, output, FREQ_W, current swept frequency.
REQ-014 SHALL have port freq_update, output, 1, one-cycle pulse when shadow_frequency is written by a sweep step.
REQ-015 SHALL have port overflow, output, 1, sticky channel-disable flag.
REQ-016 SHALL have port sweep_active, output, 1, internal sweep enable flag.

Function
REQ-017 SHALL implement states IDLE, ARMED, CALC, CHECK, OVERFLOW.
REQ-018 Arithmetic: delta = shadow >> shifts; add result computed FREQ_W+1 bits wide; overflow when result > 2^FREQ_W-1; subtract result = shadow - delta, never underflows.
REQ-019 Timer SHALL be PACE_W+1 bits; reload value = sweep_pace, or 2^PACE_W when sweep_pace = 0.
REQ-020 Trigger (any state, highest priority over tick and quirk): shadow <= frequency, timer <= reload, overflow <= 0, negate_used <= 0, sweep_active <= (pace != 0 or shifts != 0).
REQ-021 Trigger with shifts != 0 SHALL perform an overflow check on the frequency input in the same cycle; on overflow, overflow <= 1 and state -> OVERFLOW; decreasing sets negate_used.
REQ-022 Trigger next state: OVERFLOW per REQ-021, else ARMED when sweep_active, else IDLE.
REQ-023 In ARMED, CALC, CHECK, each clk_sweep cycle SHALL decrement timer; when timer = 1 it reloads instead.
REQ-024 Timer expiry in ARMED with sweep_pace != 0 SHALL go to CALC; expiry with pace = 0, or in CALC/CHECK, only reloads.
REQ-025 CALC (one cycle): compute new value; overflow -> overflow <= 1, state OVERFLOW, no write; else if shifts != 0, shadow <= new, freq_update = 1 next cycle, state CHECK; else state ARMED, no write.
REQ-026 CALC with decreasing and shifts != 0 SHALL set negate_used.
REQ-027 CHECK (one cycle): recompute from updated shadow, no write; overflow -> overflow <= 1, state OVERFLOW; else ARMED.
REQ-028 Latency: tick sampled at edge T -> shadow/freq_update valid after edge T+1 -> second check result after edge T+2.
REQ-029 freq_update SHALL be high exactly one cycle per written step; never on trigger.
REQ-030 When NEGATE_LOCK = 1, negate_used = 1 and sweep_decreasing = 0 in ARMED/CALC/CHECK SHALL set overflow and go to OVERFLOW on the next edge; ignored when NEGATE_LOCK = 0.
REQ-031 OVERFLOW and IDLE SHALL hold shadow, ignore ticks, and exit only on trigger or reset.

Reset
REQ-032 reset SHALL immediately force state IDLE, shadow_frequency 0, freq_update 0, overflow 0, sweep_active 0, timer 0, negate_used 0, regardless of clk, including mid-CALC/CHECK.

Verification
REQ-033 pace=1, decr=1, shifts=2, freq=0x040, trigger, 3 ticks -> shadow 0x030, 0x024, 0x01B; 3 freq_update pulses; overflow 0.
REQ-034 pace=1, add, shifts=1, freq=0x600, trigger -> overflow=1 after trigger edge; shadow 0x600; no freq_update; later ticks change nothing.
REQ-035 pace=1, add, shifts=2, freq=0x500, trigger, 2 ticks -> shadow 0x640 then 0x7D0; second CHECK (0x7D0+0x1F4) sets overflow; shadow stays 0x7D0.
REQ-036 pace=0, add, shifts=1, freq=0x100, trigger, 16 ticks -> sweep_active=1, shadow 0x100, no freq_update, overflow 0.
REQ-037 NEGATE_LOCK=1: decr=1, shifts=1, pace=1, freq=0x100, trigger, 1 tick (shadow 0x080), drop decr -> overflow=1 next cycle; NEGATE_LOCK=0: no overflow, next tick shadow 0x0C0.
REQ-038 reset asserted during CALC -> all outputs 0 before next clk edge; subsequent trigger restarts normally.
